// File: rtl/tick_gen.sv
// Tick source for the clock-demo counter chain: free-running prescaler in RUN,
// debounced single-step in PAUSE. Define TICK_GEN_FAST_SIM_EN for DIV_MAX=10, DEB_MAX=4.

module tick_gen_debounce #(
    parameter int DEB_MAX   = 1000000,
    parameter int DEB_WIDTH = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam logic [DEB_WIDTH-1:0] DEB_LAST = DEB_WIDTH'(DEB_MAX - 1);

    logic                 sync1;
    logic                 sync2;
    logic                 level;
    logic [DEB_WIDTH-1:0] cnt;

    // The level only moves after DEB_MAX consecutive samples disagree with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DEB_LAST) begin
                level <= sync2;
                cnt   <= '0;
                press <= sync2;
            end else begin
                cnt <= cnt + DEB_WIDTH'(1);
            end
        end
    end

endmodule

module tick_gen #(
    parameter int DIV_MAX   = 50000000,
    parameter int CNT_WIDTH = 26,
    parameter int DEB_MAX   = 1000000,
    parameter int DEB_WIDTH = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic run_key_i,
    input  logic step_key_i,
    output logic pulse_o,
    output logic running_o
);

`ifdef TICK_GEN_FAST_SIM_EN
    localparam int DIV_EFF = 10;
    localparam int DEB_EFF = 4;
`else
    localparam int DIV_EFF = DIV_MAX;
    localparam int DEB_EFF = DEB_MAX;
`endif

    localparam logic [CNT_WIDTH-1:0] DIV_LAST = CNT_WIDTH'(DIV_EFF - 1);

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] presc;
    logic [CNT_WIDTH-1:0] presc_next;
    logic                 pulse_next;
    logic                 run_ev;
    logic                 step_ev;

    tick_gen_debounce #(
        .DEB_MAX   (DEB_EFF),
        .DEB_WIDTH (DEB_WIDTH)
    ) u_run_deb (
        .clk   (clk),
        .rst   (rst),
        .key   (run_key_i),
        .press (run_ev)
    );

    tick_gen_debounce #(
        .DEB_MAX   (DEB_EFF),
        .DEB_WIDTH (DEB_WIDTH)
    ) u_step_deb (
        .clk   (clk),
        .rst   (rst),
        .key   (step_key_i),
        .press (step_ev)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            presc     <= '0;
            pulse_o   <= 1'b0;
            running_o <= 1'b1;
        end else begin
            state     <= state_next;
            presc     <= presc_next;
            pulse_o   <= pulse_next;
            running_o <= (state_next == RUN);
        end
    end

    // A terminal count that coincides with a run event still emits its pulse.
    always_comb begin
        state_next = state;
        presc_next = presc;
        pulse_next = 1'b0;
        case (state)
            RUN: begin
                pulse_next = (presc == DIV_LAST);
                presc_next = (presc == DIV_LAST) ? '0 : presc + CNT_WIDTH'(1);
                if (run_ev) begin
                    state_next = PAUSE;
                    presc_next = '0;
                end
            end
            PAUSE: begin
                pulse_next = step_ev;
                presc_next = '0;
                if (run_ev) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
                presc_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen with a small-period configuration
// (DIV_MAX=10, DEB_MAX=4): table segments, reset corner cases, random keys.

module tb_tick_gen;

    localparam int DIV = 10;
    localparam int DEB = 4;
    localparam int HL  = DEB + 2;

    typedef struct {
        logic run_key;
        logic step_key;
        int   cycles;
        int   exp_pulses;
        logic exp_running;
    } vec_t;

    logic clk        = 1'b0;
    logic rst        = 1'b0;
    logic run_key_i  = 1'b0;
    logic step_key_i = 1'b0;
    logic pulse_o;
    logic running_o;

    int   vectors = 0;
    int   errors  = 0;

    int   n;
    int   start;
    bit   m_running;
    bit   exp_pulse;
    bit   lvl     [2];
    bit   ev_prev [2];
    bit   hist    [2][HL];
    bit   last_pulse;
    int   seg_pulses;

    vec_t tbl [15];

    tick_gen #(
        .DIV_MAX   (DIV),
        .CNT_WIDTH (26),
        .DEB_MAX   (DEB),
        .DEB_WIDTH (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_key_i  (run_key_i),
        .step_key_i (step_key_i),
        .pulse_o    (pulse_o),
        .running_o  (running_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic actual, input logic expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at edge %0d: got %b, expected %b", name, n, actual, expected);
        end
    endtask

    task automatic check_count(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        n          = 0;
        start      = 0;
        m_running  = 1'b1;
        exp_pulse  = 1'b0;
        last_pulse = 1'b0;
        for (int k = 0; k < 2; k++) begin
            lvl[k]     = 1'b0;
            ev_prev[k] = 1'b0;
            for (int i = 0; i < HL; i++) hist[k][i] = 1'b0;
        end
    endtask

    // Raw key history per key; a key level is adopted once the synchronised
    // value (two samples old) has disagreed with it for DEB samples in a row.
    task automatic model_edge(input bit rk, input bit sk);
        bit ev_now [2];
        bit differs;
        n++;
        for (int k = 0; k < 2; k++) begin
            for (int i = HL - 1; i > 0; i--) hist[k][i] = hist[k][i-1];
        end
        hist[0][0] = rk;
        hist[1][0] = sk;
        if (m_running) begin
            exp_pulse = ((n - start) % DIV == 0);
            if (ev_prev[0]) m_running = 1'b0;
        end else begin
            exp_pulse = ev_prev[1];
            if (ev_prev[0]) begin
                m_running = 1'b1;
                start     = n;
            end
        end
        for (int k = 0; k < 2; k++) begin
            ev_now[k] = 1'b0;
            differs   = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (hist[k][2+j] == lvl[k]) differs = 1'b0;
            end
            if (differs) begin
                lvl[k]    = hist[k][2];
                ev_now[k] = lvl[k];
            end
        end
        ev_prev[0] = ev_now[0];
        ev_prev[1] = ev_now[1];
    endtask

    task automatic apply_stimulus(input logic rk, input logic sk);
        run_key_i  = rk;
        step_key_i = sk;
        @(posedge clk);
        model_edge(rk, sk);
        @(negedge clk);
        check_output("pulse_o", pulse_o, exp_pulse);
        check_output("running_o", running_o, m_running);
        check_output("pulse_pair", pulse_o & last_pulse, 1'b0);
        last_pulse = pulse_o;
        if (pulse_o) seg_pulses++;
    endtask

    task automatic apply_reset();
        run_key_i  = 1'b0;
        step_key_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_output("reset_pulse", pulse_o, 1'b0);
        check_output("reset_running", running_o, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic measure_first_pulse(input string name);
        int first;
        first = 0;
        for (int i = 1; i <= DIV + 2; i++) begin
            apply_stimulus(1'b0, 1'b0);
            if (pulse_o && first == 0) first = i;
        end
        check_count(name, first, DIV);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 60, 6, 1'b1};
        tbl[1]  = '{1'b1, 1'b0,  8, 0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 50, 0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1,  8, 1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 10, 0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1,  8, 1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 10, 0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1,  8, 1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 10, 0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1,  3, 0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 10, 0, 1'b0};
        tbl[11] = '{1'b1, 1'b1,  8, 1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 20, 2, 1'b1};
        tbl[13] = '{1'b0, 1'b1,  8, 0, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 20, 2, 1'b1};

        model_reset();
        seg_pulses = 0;
        apply_reset();

        for (int i = 0; i < 15; i++) begin
            seg_pulses = 0;
            for (int c = 0; c < tbl[i].cycles; c++) begin
                apply_stimulus(tbl[i].run_key, tbl[i].step_key);
            end
            check_count($sformatf("seg%0d_pulses", i), seg_pulses, tbl[i].exp_pulses);
            check_output($sformatf("seg%0d_running", i), running_o, tbl[i].exp_running);
        end

        // Reset with the prescaler part-way through a period.
        apply_reset();
        for (int i = 0; i < 7; i++) apply_stimulus(1'b0, 1'b0);
        apply_reset();
        measure_first_pulse("first_pulse_mid_count");

        // Reset while a pulse is on the output.
        for (int i = 0; i < DIV - 2; i++) apply_stimulus(1'b0, 1'b0);
        check_output("pulse_before_reset", pulse_o, 1'b1);
        apply_reset();
        measure_first_pulse("first_pulse_after_pulse_reset");

        // Reset while paused.
        for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b0);
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b0);
        check_output("paused_before_reset", running_o, 1'b0);
        apply_reset();
        measure_first_pulse("first_pulse_after_pause_reset");

        // Random key activity against the reference model.
        apply_reset();
        for (int s = 0; s < 150; s++) begin
            logic rk;
            logic sk;
            int   len;
            rk  = ($urandom_range(0, 3) == 0);
            sk  = $urandom_range(0, 1) == 1;
            len = $urandom_range(1, 10);
            for (int c = 0; c < len; c++) apply_stimulus(rk, sk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/tick_gen.md
Name: tick_gen

Overview:
- Upstream pulse source for the clock-demo counter chain. Produces the single-cycle pulse that drives each counter's pulse input.
- In RUN, free-runs a prescaler and emits one pulse every DIV_MAX clocks (1 Hz at 50 MHz by default).
- In PAUSE, the prescaler is frozen and a debounced STEP key emits exactly one pulse per press.
- A debounced RUN key toggles between RUN and PAUSE.

Parameters:
- DIV_MAX, 50000000, prescaler period in clk cycles; legal range is 2 or more.
- CNT_WIDTH, 26, prescaler counter width; must hold DIV_MAX-1.
- DEB_MAX, 1000000, number of consecutive stable cycles needed to accept a key level change (20 ms at 50 MHz); legal range is 1 or more.
- DEB_WIDTH, 20, debounce counter width; must hold DEB_MAX-1.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- run_key_i  input  1  raw RUN/PAUSE push button, active-high, asynchronous to clk.
- step_key_i  input  1  raw STEP push button, active-high, asynchronous to clk.
- pulse_o  output  1  registered tick, high for exactly one clk cycle; connects to the counter's pulse input.
- running_o  output  1  registered; 1 in RUN state, 0 in PAUSE state.

Behaviour:
- Reset (asynchronous, rst=1) sets the following:
  - state=RUN, running_o=1, pulse_o=0, prescaler=0.
  - Both synchronizers, debounce counters and debounced levels are 0, and key events are 0.
- Key path (identical for each key):
  - Two-flop synchronizer produces s.
  - Debounce counter: if s equals the debounced level, cnt is set to 0. Otherwise, if cnt==DEB_MAX-1, the debounced level takes s and cnt is set to 0. Otherwise cnt increments by 1.
  - Press event: registered one-cycle strobe, set on the same edge that changes the debounced level from 0 to 1. Release (1 to 0) generates no event.
  - A glitch shorter than DEB_MAX cycles at s is ignored.
  - Holding the key generates one event only.
- State machine has two states, RUN and PAUSE.
  - RUN: a run event moves to PAUSE and clears the prescaler to 0.
  - PAUSE: a run event moves to RUN and clears the prescaler to 0.
  - running_o is updated on the same edge as the state.
- RUN prescaler:
  - Counts 0 to DIV_MAX-1 and wraps to 0.
  - pulse_o <= (prescaler==DIV_MAX-1), so the first pulse_o occurs DIV_MAX edges after reset release or after entering RUN, with period DIV_MAX.
  - Step events are ignored in RUN.
- PAUSE:
  - The prescaler holds at 0.
  - pulse_o <= step event, so the pulse appears one cycle after the event strobe, DEB_MAX+2 edges after the edge that first samples the raw key high.
- Simultaneous events:
  - RUN, with terminal count coinciding with a run event: pulse_o is still emitted, then the state becomes PAUSE.
  - PAUSE, with step and run events in the same cycle: one pulse_o is emitted and the state becomes RUN with the prescaler at 0.
- pulse_o is never high for two consecutive cycles, since DIV_MAX is at least 2 and events are strobes.
- Reset mid-operation: immediately returns to the reset values above. No partial pulse is generated.

Optional Feature:
- Macro: TICK_GEN_FAST_SIM_EN.
- Defined: the effective DIV_MAX is 10 and the effective DEB_MAX is 4, overriding the parameters. This is for simulation only.
- Not defined: the parameter values are used unchanged.
- The logic structure is the same in both cases.

Test Plan:
All scenarios are built with TICK_GEN_FAST_SIM_EN defined (DIV_MAX=10, DEB_MAX=4).
1. Release rst and run 60 cycles with no keys -> running_o=1; pulse_o is high single-cycle on edges 10, 20, 30, 40, 50, 60 after release (6 pulses).
2. Hold run_key_i high for 8 cycles -> exactly one toggle to running_o=0. No pulse_o for the next 50 cycles and the prescaler stays at 0.
3. In PAUSE, press step_key_i for 8 cycles, three times with 10-cycle gaps -> exactly 3 pulses, each at DEB_MAX+2=6 edges after the raw press. Then apply a 3-cycle step glitch -> no pulse.
4. In PAUSE, assert run and step on the same cycle for 8 cycles -> one pulse_o and running_o=1, then the next pulse 10 edges later.
5. In RUN, press step 8 cycles -> pulse cadence unchanged (no extra pulse).
6. Assert rst asynchronously mid-count (prescaler=7) and also while PAUSE is active -> pulse_o=0 and running_o=1 immediately; the first pulse comes 10 edges after release.
